multicycle_core_param: RTL and testbench

- Parametrised next-generation multicycle processor core: FSM control unit, PC, IR, register file and ALU in one block.
- Generalised data width, address width and register count.
- Harvard split with separate instruction and data memory ports, each using a req/ready handshake that tolerates wait states.
- Adds branch, jump, illegal-opcode detection and a retired-instruction counter; memories are external to this block.

---
 rtl/multicycle_core_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_core_param.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core_param.sv
// ---------------------------------------------------------------------------
// multicycle_core_param
//   Parametrised multicycle processor core with an FSM control unit, PC, IR,
//   register file and ALU. Instruction and data memories are external. Both
//   memory ports use a req/ready handshake that tolerates wait states.
//
//   Instruction word: op[15:12] rd[11:8] rs[7:4] rt/imm4[3:0]
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start               leave IDLE and begin fetching at PC
//   imem_req/addr       fetch request, address = PC
//   imem_rdata/ready    instruction word, valid in the ready cycle
//   dmem_req/we/addr    data access request, 1 = store, data address
//   dmem_wdata          store data
//   dmem_rdata/ready    load data, valid in the ready cycle
//   pc_out, ir_out      architectural PC and instruction register
//   state_out           FSM state code
//   halt, illegal       halted; sticky flag for an undefined opcode
//   instret             retired-instruction counter (wraps at 2^32)
// ---------------------------------------------------------------------------
module multicycle_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       ir_out,
    output logic [2:0]        state_out,
    output logic              halt,
    output logic              illegal,
    output logic [31:0]       instret
);

    localparam int RIW = $clog2(NREG);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] opd_q, opd_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       instret_q, instret_d;

    // Instruction fields; register indices use only the low log2(NREG) bits.
    logic [3:0]        op;
    logic [RIW-1:0]    rd_idx, rs_idx, rt_idx;
    logic signed [3:0] imm4;
    logic [DATA_W-1:0] simm_dw;
    logic [ADDR_W-1:0] simm_aw;

    assign op      = ir_q[15:12];
    assign rd_idx  = ir_q[8 +: RIW];
    assign rs_idx  = ir_q[4 +: RIW];
    assign rt_idx  = ir_q[0 +: RIW];
    assign imm4    = ir_q[3:0];
    assign simm_dw = DATA_W'(imm4);
    assign simm_aw = ADDR_W'(imm4);

    // ADDI, LD and ST all compute rs + simm; LD/ST use it as the address.
    function automatic logic [DATA_W-1:0] alu(input logic [3:0]        f,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] s);
        case (f)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a + s;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        regs_d       = regs_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opd_d        = opd_q;
        res_d        = res_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        illegal_d    = illegal_q;
        instret_d    = instret_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opa_d = regs_q[rs_idx];
                opb_d = regs_q[rt_idx];
                opd_d = regs_q[rd_idx];
                case (op)
                    OP_NOP: begin
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    OP_BEQ: begin
                        // PC already points past the branch.
                        if (regs_q[rd_idx] == regs_q[rs_idx]) pc_d = pc_q + simm_aw;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d      = ADDR_W'(ir_q[11:0]);
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST:
                        state_d = S_EXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                res_d = alu(op, opa_q, opb_q, simm_dw);
                if (op == OP_LD || op == OP_ST) begin
                    // Address is the low ADDR_W bits, zero-extended if narrower.
                    dmem_addr_d  = ADDR_W'(alu(op, opa_q, opb_q, simm_dw));
                    dmem_wdata_d = opd_q;
                    dmem_we_d    = (op == OP_ST);
                    state_d      = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    dmem_we_d = 1'b0;
                    if (op == OP_LD) begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                regs_d[rd_idx] = res_q;
                instret_d      = instret_q + 32'd1;
                state_d        = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            opd_q        <= '0;
            res_q        <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            illegal_q    <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            regs_q       <= regs_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opd_q        <= opd_d;
            res_q        <= res_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            illegal_q    <= illegal_d;
            instret_q    <= instret_d;
        end
    end

    // Requests are pure state decodes, so they drop with reset and in the
    // cycle after ready, and can never overlap.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign pc_out     = pc_q;
    assign ir_out     = ir_q;
    assign state_out  = state_q;
    assign halt       = (state_q == S_HALT);
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_core_param.sv
`timescale 1ns/1ps
module tb_multicycle_core_param;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [AW-1:0] imem_addr, dmem_addr, pc_out;
    logic [15:0]   imem_rdata, ir_out;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic [2:0]    state_out;
    logic          halt, illegal;
    logic [31:0]   instret;

    multicycle_core_param #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc_out(pc_out), .ir_out(ir_out), .state_out(state_out), .halt(halt),
        .illegal(illegal), .instret(instret)
    );

    // Second instance: wide data path, 16 registers, zero-wait memories.
    logic          start2 = 1'b0;
    logic          imem2_req, imem2_ready, dmem2_req, dmem2_we, dmem2_ready;
    logic [7:0]    imem2_addr, dmem2_addr, pc2_out;
    logic [15:0]   imem2_rdata, ir2_out, dmem2_wdata, dmem2_rdata;
    logic [2:0]    state2_out;
    logic          halt2, illegal2;
    logic [31:0]   instret2;

    multicycle_core_param #(.DATA_W(16), .ADDR_W(8), .NREG(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .imem_req(imem2_req), .imem_addr(imem2_addr), .imem_rdata(imem2_rdata), .imem_ready(imem2_ready),
        .dmem_req(dmem2_req), .dmem_we(dmem2_we), .dmem_addr(dmem2_addr), .dmem_wdata(dmem2_wdata),
        .dmem_rdata(dmem2_rdata), .dmem_ready(dmem2_ready),
        .pc_out(pc2_out), .ir_out(ir2_out), .state_out(state2_out), .halt(halt2),
        .illegal(illegal2), .instret(instret2)
    );

    always #5 clk = ~clk;

    // Memory models with programmable wait states.
    logic [15:0] imem  [256];
    logic [7:0]  dmem  [256];
    logic [15:0] imem2 [256];
    logic [15:0] dmem2 [256];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

    assign imem_ready  = imem_req && (icnt >= iwait);
    assign imem_rdata  = imem[imem_addr];
    assign dmem_ready  = dmem_req && (dcnt >= dwait);
    assign dmem_rdata  = dmem[dmem_addr];
    assign imem2_ready = imem2_req;
    assign imem2_rdata = imem2[imem2_addr];
    assign dmem2_ready = dmem2_req;
    assign dmem2_rdata = dmem2[dmem2_addr];

    always @(posedge clk) begin
        if (imem_req && !imem_ready) icnt <= icnt + 1; else icnt <= 0;
        if (dmem_req && !dmem_ready) dcnt <= dcnt + 1; else dcnt <= 0;
    end

    // Scoreboards: expected data transactions and expected fetch addresses.
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } dx_t;
    dx_t        dq[$];
    logic [7:0] fq[$];
    bit         chk_fetch = 1'b0;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Handshake monitor, sampled mid-cycle.
    logic        ip_wait = 1'b0, dp_wait = 1'b0, dreq_prev = 1'b0;
    logic [7:0]  ip_addr = '0;
    logic [16:0] dp_sig = '0;
    int          dbursts = 0, both_cnt = 0, ireq_cnt = 0;

    always @(negedge clk) begin
        dx_t        x;
        logic [7:0] fa;
        if (imem_req && dmem_req) both_cnt++;
        if (imem_req) ireq_cnt++;
        if (ip_wait && imem_req) check("imem_addr_stable", imem_addr, ip_addr);
        ip_wait = imem_req && !imem_ready;
        ip_addr = imem_addr;
        if (dp_wait && dmem_req) check("dmem_stable", {dmem_we, dmem_addr, dmem_wdata}, dp_sig);
        dp_wait = dmem_req && !dmem_ready;
        dp_sig  = {dmem_we, dmem_addr, dmem_wdata};
        if (dmem_req && !dreq_prev) dbursts++;
        dreq_prev = dmem_req;
        if (imem_req && imem_ready && chk_fetch) begin
            if (fq.size() == 0) begin
                n_chk++;
                $display("FAIL fetch_extra: got fetch at 0x%0h expected none", imem_addr);
            end else begin
                fa = fq.pop_front();
                check("fetch_addr", imem_addr, fa);
            end
        end
        if (dmem_req && dmem_ready) begin
            if (dq.size() == 0) begin
                n_chk++;
                $display("FAIL dmem_extra: got access we=%0d addr=0x%0h expected none", dmem_we, dmem_addr);
            end else begin
                x = dq.pop_front();
                check("dmem_we", dmem_we, x.we);
                check("dmem_addr", dmem_addr, x.addr);
                if (x.we) check("dmem_wdata", dmem_wdata, x.data);
            end
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        end
        if (dmem2_req && dmem2_we) dmem2[dmem2_addr] = dmem2_wdata;
    end

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        chk_fetch = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 8'h00;
        end
        dq.delete();
        fq.delete();
        iwait = 0;
        dwait = 0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic run_prog(input string tag, input int exp_cyc, input int exp_ret);
        int n;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!halt && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_cycles"}, n, exp_cyc);
        check({tag, "_halt"}, halt, 1'b1);
        check({tag, "_instret"}, instret, exp_ret);
        check({tag, "_dq_empty"}, dq.size(), 0);
    endtask

    task automatic load_p1();
        imem[0] = ins(4'h5, 4'd1, 4'd0, 4'd3);
        imem[1] = ins(4'h5, 4'd2, 4'd0, 4'd5);
        imem[2] = ins(4'h1, 4'd1, 4'd1, 4'd2);
        imem[3] = 16'hF000;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[9];

    initial begin
        int c0, n;
        vt[0] = '{4'h1, 4'h3, 4'h5, 8'h08};
        vt[1] = '{4'h2, 4'h3, 4'h5, 8'hFE};
        vt[2] = '{4'h3, 4'hF, 4'h5, 8'h05};
        vt[3] = '{4'h4, 4'h2, 4'h5, 8'h07};
        vt[4] = '{4'h5, 4'h7, 4'h8, 8'hFF};
        vt[5] = '{4'h2, 4'h8, 4'h7, 8'hF1};
        vt[6] = '{4'h3, 4'h8, 4'hD, 8'hF8};
        vt[7] = '{4'h4, 4'h8, 4'h3, 8'hFB};
        vt[8] = '{4'h1, 4'h8, 4'h8, 8'hF0};

        // Reset state and idle without start.
        do_reset();
        check("rst_state", state_out, 3'd0);
        check("rst_pc", pc_out, 8'h00);
        check("rst_ir", ir_out, 16'h0000);
        check("rst_halt", halt, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_dmem_addr", dmem_addr, 8'h00);
        check("rst_dmem_wdata", dmem_wdata, 8'h00);
        check("rst_instret", instret, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("idle_hold", state_out, 3'd0);

        // Arithmetic program, zero-wait fetches.
        load_p1();
        run_prog("p1", 14, 3);
        check("p1_r1", dut.regs_q[1], 8'h08);
        check("p1_pc", pc_out, 8'h04);
        check("p1_state", state_out, 3'd7);
        check("p1_illegal", illegal, 1'b0);
        check("p1_imem_req", imem_req, 1'b0);

        // Same program, three wait cycles on each of the four fetches.
        do_reset();
        load_p1();
        iwait = 3;
        run_prog("p1w", 26, 3);
        check("p1w_r1", dut.regs_q[1], 8'h08);
        check("p1w_pc", pc_out, 8'h04);

        // Store/load round trip through data memory with wait states.
        do_reset();
        dmem[5] = 8'h7F;
        imem[0] = ins(4'h6, 4'd1, 4'd0, 4'd5);
        imem[1] = ins(4'h7, 4'd1, 4'd0, 4'd2);
        imem[2] = ins(4'h6, 4'd3, 4'd0, 4'd2);
        imem[3] = ins(4'h7, 4'd3, 4'd0, 4'd3);
        dq.push_back('{1'b0, 8'd5, 8'h00});
        dq.push_back('{1'b1, 8'd2, 8'h7F});
        dq.push_back('{1'b0, 8'd2, 8'h00});
        dq.push_back('{1'b1, 8'd3, 8'h7F});
        dwait = 2;
        c0 = dbursts;
        run_prog("ldst", 28, 4);
        check("ldst_bursts", dbursts - c0, 4);
        check("ldst_mem3", dmem[3], 8'h7F);
        check("ldst_r3", dut.regs_q[3], 8'h7F);

        // Branches and jumps, including a jump to the top of the address space.
        do_reset();
        imem[0]   = ins(4'h8, 4'd1, 4'd0, 4'd2);
        imem[1]   = 16'hF000;
        imem[3]   = 16'h9005;
        imem[5]   = ins(4'h8, 4'd0, 4'd0, 4'hE);
        imem[4]   = 16'h90FF;
        imem[255] = ins(4'h5, 4'd1, 4'd1, 4'd1);
        fq.push_back(8'h00); fq.push_back(8'h03); fq.push_back(8'h05); fq.push_back(8'h04);
        fq.push_back(8'hFF); fq.push_back(8'h00); fq.push_back(8'h01);
        chk_fetch = 1'b1;
        run_prog("br", 16, 6);
        check("br_pc", pc_out, 8'h02);
        check("br_fq_empty", fq.size(), 0);
        chk_fetch = 1'b0;

        // Undefined opcode halts; later start is ignored.
        do_reset();
        imem[0] = ins(4'h5, 4'd1, 4'd0, 4'd1);
        imem[1] = 16'hB123;
        run_prog("ill", 6, 1);
        check("ill_flag", illegal, 1'b1);
        check("ill_state", state_out, 3'd7);
        check("ill_pc", pc_out, 8'h02);
        check("ill_ir", ir_out, 16'hB123);
        c0 = ireq_cnt;
        @(negedge clk) start = 1'b1;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        check("ill_no_fetch", ireq_cnt - c0, 0);
        check("ill_stays", state_out, 3'd7);
        check("ill_instret", instret, 32'd1);

        // ALU vectors, each result stored to address 1.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            imem[0] = ins(4'h5, 4'd1, 4'd0, vt[i].a);
            imem[1] = ins(4'h5, 4'd2, 4'd0, vt[i].b);
            imem[2] = (vt[i].op == 4'h5) ? ins(4'h5, 4'd3, 4'd1, vt[i].b)
                                         : ins(vt[i].op, 4'd3, 4'd1, 4'd2);
            imem[3] = ins(4'h7, 4'd3, 4'd0, 4'd1);
            dq.push_back('{1'b1, 8'd1, vt[i].exp});
            run_prog($sformatf("vec%0d", i), 18, 4);
        end

        // Asynchronous reset in the middle of a store handshake.
        do_reset();
        imem[0] = ins(4'h5, 4'd1, 4'd0, 4'd5);
        imem[1] = ins(4'h7, 4'd1, 4'd1, 4'd1);
        dwait = 50;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!dmem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_state", state_out, 3'd4);
        check("mid_we", dmem_we, 1'b1);
        check("mid_addr", dmem_addr, 8'h06);
        check("mid_wdata", dmem_wdata, 8'h05);
        #2 reset_n = 1'b0;
        #1;
        check("arst_dmem_req", dmem_req, 1'b0);
        check("arst_state", state_out, 3'd0);
        check("arst_pc", pc_out, 8'h00);
        check("arst_ir", ir_out, 16'h0000);
        check("arst_we", dmem_we, 1'b0);
        check("arst_addr", dmem_addr, 8'h00);
        check("arst_wdata", dmem_wdata, 8'h00);
        check("arst_instret", instret, 32'd0);
        check("arst_imem_req", imem_req, 1'b0);
        check("arst_r1", dut.regs_q[1], 8'h00);
        @(negedge clk) reset_n = 1'b1;

        // Wide instance: 0x7FFF + 1 wraps to 0x8000, using register 15.
        for (int i = 0; i < 256; i++) begin
            imem2[i] = 16'hF000;
            dmem2[i] = 16'h0000;
        end
        dmem2[0] = 16'h7FFF;
        imem2[0] = ins(4'h6, 4'd15, 4'd0, 4'd0);
        imem2[1] = ins(4'h5, 4'd15, 4'd15, 4'd1);
        imem2[2] = ins(4'h7, 4'd15, 4'd0, 4'd1);
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (!halt2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w16_cycles", n, 15);
        check("w16_store", dmem2[1], 16'h8000);
        check("w16_instret", instret2, 32'd3);

        check("never_both_req", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
